decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter EN_MEXT, default 0; 1 enables RV32M decode (mul/mulh/mulhsu/mulhu/div/divu/rem/remu).
REQ-002 Parameter MUL_LAT, default 2; issue-hold cycles after a multiply handshake, legal range 1..15.
REQ-003 Parameter DIV_LAT, default 8; issue-hold cycles after a div/rem handshake, legal range 1..15.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 Port instruction, input, 32: instruction word from fetch.
REQ-007 Ports in_valid (input, 1) and in_ready (output, 1): upstream handshake.
REQ-008 Ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.
REQ-009 Port flush, input, 1: kill the held or in-flight instruction.
REQ-010 Registered control outputs: RegWrite 1, ALUSrc 1, ALUCtrl 5, IMMSrc 3, MemWrite 1, ResultSrc 2, branch 1, MemCtrl 3, jump 1, JALROn 1.
REQ-011 Port illegal, output, 1: the held instruction is undecodable.
REQ-012 Port busy, output, 1: a multicycle hold is in progress.

Function
REQ-013 Accept the input when in_valid && in_ready; decoded controls register on that edge, so latency is 1 cycle.
REQ-014 Use a three-state FSM: IDLE (nothing held), VALID (controls held, out_valid=1), WAIT (multicycle countdown, out_valid=0, busy=1).
REQ-015 Transitions: IDLE+accept->VALID; VALID+out_ready+non-M->VALID if a new accept occurs, else IDLE; VALID+out_ready+M->WAIT, count loaded with LAT-1; WAIT with count 0->IDLE, otherwise decrement.
REQ-016 in_ready = (state==IDLE) || (state==VALID && out_ready && held op not M) || (state==WAIT && count==0), always gated by !flush.
REQ-017 While out_valid=1 and out_ready=0, every control output stays stable.
REQ-018 flush forces the state to IDLE and clears out_valid and busy next cycle; it wins over an accept in the same cycle and aborts WAIT at any count.
REQ-019 Decode is the RV32I base set: R, I-ALU, load, store, branch, jal, jalr, lui, auipc, with the same ALUCtrl/IMMSrc/MemCtrl codes the existing control path uses.
REQ-020 ResultSrc encoding: 0 ALU, 1 memory, 2 PC+4, 3 PC+imm; auipc uses ResultSrc=3 with IMMSrc=U.
REQ-021 For non-memory ops, MemCtrl shall be MEM_W; no output is left undriven on any path.
REQ-022 Illegal cases are: unknown opcode, reserved funct3, and funct7 not in {0x00, 0x20}, plus 0x01 when EN_MEXT=1.
REQ-023 An illegal instruction is held with out_valid=1, illegal=1, RegWrite=0, MemWrite=0, branch=0, jump=0.
REQ-024 With EN_MEXT=0, funct7=0x01 on opcode 0110011 shall be illegal.
REQ-025 With EN_MEXT=1, M ops drive RegWrite=1, ALUSrc=0 and ALUCtrl from ALU_MUL..ALU_REMU; mul* use MUL_LAT and div/rem use DIV_LAT.
REQ-026 Shift-immediate with imm[11:5] not in {0x00, 0x20} shall be illegal.

Reset
REQ-027 While rst_n=0 at a clock edge: state=IDLE, out_valid=0, busy=0, illegal=0, count=0.
REQ-028 While rst_n=0 at a clock edge, all controls take default values: ALUCtrl=ALU_ADD, ALUSrc=1, MemCtrl=MEM_W, all others 0.
REQ-029 in_ready shall be 0 while rst_n=0.
REQ-030 Reset asserted during WAIT or VALID abandons the held op, with no output pulse afterwards.

Structure
REQ-031 The shared package holds ALU_*, SIGN_EXTEND_*, MEM_* and RESULT_* constants, the new ALU_MUL..ALU_REMU codes, the opcode constants and the FSM state enum.
REQ-032 One sub-module, decode_comb, holds the pure combinational instruction->controls decode (with EN_MEXT as a parameter) and produces is_mul, is_div and illegal.
REQ-033 decode_stage holds only the FSM, the counter and the output registers.

Verification
REQ-034 Scenario: add 0x002081B3 accepted -> next cycle out_valid=1, RegWrite=1, ALUSrc=0, ALUCtrl=ALU_ADD, illegal=0.
REQ-035 Scenario: back-to-back with out_ready=1 (lw 0x0000A183 then sw 0x0030A023) -> one result per cycle; lw gives ResultSrc=1, MemCtrl=MEM_W; sw gives MemWrite=1, RegWrite=0.
REQ-036 Scenario: EN_MEXT=1, DIV_LAT=8, div 0x0220C1B3 consumed -> busy=1 and in_ready=0 for 7 cycles, in_ready=1 on the 8th.
REQ-037 Scenario: EN_MEXT=0, mul 0x022081B3 -> illegal=1, RegWrite=0, out_valid=1.
REQ-038 Scenario: out_ready=0 for 5 cycles on a held beq 0x00208463 -> outputs stable, in_ready=0; flush asserted in WAIT at count 3 -> IDLE next cycle, busy=0.
REQ-039 Scenario: rst_n=0 for 1 cycle mid-VALID -> out_valid=0 and all outputs at default the next cycle.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared encodings for the decode stage: ALU/immediate/memory/result codes,
// opcodes, the held-control bundle and the stage FSM states.
package decode_stage_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    localparam logic [2:0] SIGN_EXTEND_I = 3'd0;
    localparam logic [2:0] SIGN_EXTEND_S = 3'd1;
    localparam logic [2:0] SIGN_EXTEND_B = 3'd2;
    localparam logic [2:0] SIGN_EXTEND_U = 3'd3;
    localparam logic [2:0] SIGN_EXTEND_J = 3'd4;

    // Memory access codes mirror the load/store funct3 field.
    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_HU = 3'd5;

    localparam logic [1:0] RESULT_ALU   = 2'd0;
    localparam logic [1:0] RESULT_MEM   = 2'd1;
    localparam logic [1:0] RESULT_PC4   = 2'd2;
    localparam logic [1:0] RESULT_PCIMM = 2'd3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MEXT = 7'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic [4:0] alu_ctrl;
        logic [2:0] imm_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [2:0] mem_ctrl;
        logic       jump;
        logic       jalr_on;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        reg_write: 1'b0, alu_src: 1'b1, alu_ctrl: ALU_ADD, imm_src: SIGN_EXTEND_I,
        mem_write: 1'b0, result_src: RESULT_ALU, branch: 1'b0, mem_ctrl: MEM_W,
        jump: 1'b0, jalr_on: 1'b0, illegal: 1'b0
    };

    // Base-ISA ALU op selected by funct3 with the "normal" funct7 variant.
    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'd0:    alu_base = ALU_ADD;
            3'd1:    alu_base = ALU_SLL;
            3'd2:    alu_base = ALU_SLT;
            3'd3:    alu_base = ALU_SLTU;
            3'd4:    alu_base = ALU_XOR;
            3'd5:    alu_base = ALU_SRL;
            3'd6:    alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_decode_comb.sv
// Pure combinational RV32I (+ optional RV32M) instruction -> control decode.
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter bit EN_MEXT = 1'b0
) (
    input  logic [31:0] instruction,
    output logic        reg_write,
    output logic        alu_src,
    output logic [4:0]  alu_ctrl,
    output logic [2:0]  imm_src,
    output logic        mem_write,
    output logic [1:0]  result_src,
    output logic        branch,
    output logic [2:0]  mem_ctrl,
    output logic        jump,
    output logic        jalr_on,
    output logic        is_mul,
    output logic        is_div,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign funct7        = instruction[31:25];
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};

    always_comb begin
        reg_write  = 1'b0;
        alu_src    = 1'b1;
        alu_ctrl   = ALU_ADD;
        imm_src    = SIGN_EXTEND_I;
        mem_write  = 1'b0;
        result_src = RESULT_ALU;
        branch     = 1'b0;
        mem_ctrl   = MEM_W;
        jump       = 1'b0;
        jalr_on    = 1'b0;
        is_mul     = 1'b0;
        is_div     = 1'b0;
        illegal    = 1'b0;

        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_src   = 1'b0;
                if (EN_MEXT && funct7 == F7_MEXT) begin
                    case (funct3)
                        3'd0:    alu_ctrl = ALU_MUL;
                        3'd1:    alu_ctrl = ALU_MULH;
                        3'd2:    alu_ctrl = ALU_MULHSU;
                        3'd3:    alu_ctrl = ALU_MULHU;
                        3'd4:    alu_ctrl = ALU_DIV;
                        3'd5:    alu_ctrl = ALU_DIVU;
                        3'd6:    alu_ctrl = ALU_REM;
                        default: alu_ctrl = ALU_REMU;
                    endcase
                    is_mul = !funct3[2];
                    is_div = funct3[2];
                end else if (funct7 == F7_BASE) begin
                    alu_ctrl = alu_base(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
                    alu_ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
                    alu_ctrl = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_ctrl  = alu_base(funct3);
                // Shift-immediates reuse imm[11:5] as a funct7-like qualifier.
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    if (funct7 != F7_BASE && funct7 != F7_ALT)
                        illegal = 1'b1;
                    else if (funct3 == 3'd5 && funct7 == F7_ALT)
                        alu_ctrl = ALU_SRA;
                end
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                result_src = RESULT_MEM;
                case (funct3)
                    3'd0:    mem_ctrl = MEM_B;
                    3'd1:    mem_ctrl = MEM_H;
                    3'd2:    mem_ctrl = MEM_W;
                    3'd4:    mem_ctrl = MEM_BU;
                    3'd5:    mem_ctrl = MEM_HU;
                    default: illegal  = 1'b1;
                endcase
            end
            OP_STORE: begin
                mem_write = 1'b1;
                imm_src   = SIGN_EXTEND_S;
                case (funct3)
                    3'd0:    mem_ctrl = MEM_B;
                    3'd1:    mem_ctrl = MEM_H;
                    3'd2:    mem_ctrl = MEM_W;
                    default: illegal  = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                alu_src = 1'b0;
                imm_src = SIGN_EXTEND_B;
                case (funct3)
                    3'd0, 3'd1: alu_ctrl = ALU_SUB;
                    3'd4, 3'd5: alu_ctrl = ALU_SLT;
                    3'd6, 3'd7: alu_ctrl = ALU_SLTU;
                    default:    illegal  = 1'b1;
                endcase
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                imm_src    = SIGN_EXTEND_J;
                result_src = RESULT_PC4;
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                jalr_on    = 1'b1;
                result_src = RESULT_PC4;
                if (funct3 != 3'd0)
                    illegal = 1'b1;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                imm_src   = SIGN_EXTEND_U;
                alu_ctrl  = ALU_LUI;
            end
            OP_AUIPC: begin
                reg_write  = 1'b1;
                imm_src    = SIGN_EXTEND_U;
                result_src = RESULT_PCIMM;
            end
            default: illegal = 1'b1;
        endcase

        // An undecodable word must not cause any side effect downstream.
        if (illegal) begin
            reg_write  = 1'b0;
            alu_src    = 1'b1;
            alu_ctrl   = ALU_ADD;
            imm_src    = SIGN_EXTEND_I;
            mem_write  = 1'b0;
            result_src = RESULT_ALU;
            branch     = 1'b0;
            mem_ctrl   = MEM_W;
            jump       = 1'b0;
            jalr_on    = 1'b0;
            is_mul     = 1'b0;
            is_div     = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-deep control register with valid/ready handshakes and a
// countdown that blocks issue after a multiply/divide leaves the stage.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter bit EN_MEXT = 1'b0,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flush,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [4:0]  ALUCtrl,
    output logic [2:0]  IMMSrc,
    output logic        MemWrite,
    output logic [1:0]  ResultSrc,
    output logic        branch,
    output logic [2:0]  MemCtrl,
    output logic        jump,
    output logic        JALROn,
    output logic        illegal,
    output logic        busy
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    ctrl_t      ctrl_q, ctrl_d;
    logic       held_m;
    logic [3:0] held_cnt;
    logic       accept;

    logic       d_rw, d_as, d_mw, d_br, d_jp, d_jr, d_mul, d_div, d_ill;
    logic [4:0] d_alu;
    logic [2:0] d_imm, d_mc;
    logic [1:0] d_rs;

    decode_comb #(.EN_MEXT(EN_MEXT)) u_dec (
        .instruction (instruction),
        .reg_write   (d_rw),
        .alu_src     (d_as),
        .alu_ctrl    (d_alu),
        .imm_src     (d_imm),
        .mem_write   (d_mw),
        .result_src  (d_rs),
        .branch      (d_br),
        .mem_ctrl    (d_mc),
        .jump        (d_jp),
        .jalr_on     (d_jr),
        .is_mul      (d_mul),
        .is_div      (d_div),
        .illegal     (d_ill)
    );

    assign ctrl_d = {d_rw, d_as, d_alu, d_imm, d_mw, d_rs, d_br, d_mc, d_jp, d_jr, d_ill};

    assign in_ready = rst_n && !flush &&
                      ((state == ST_IDLE) ||
                       (state == ST_VALID && out_ready && !held_m) ||
                       (state == ST_WAIT && cnt == 4'd0));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nx = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready) begin
                    if (held_m) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = held_cnt;
                    end else begin
                        state_nx = accept ? ST_VALID : ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                // The last hold cycle already advertises ready, so a word
                // taken then goes straight to VALID.
                if (cnt == 4'd0)
                    state_nx = accept ? ST_VALID : ST_IDLE;
                else
                    cnt_nx = cnt - 4'd1;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (flush) begin
            state_nx = ST_IDLE;
            cnt_nx   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            ctrl_q   <= CTRL_DEFAULT;
            held_m   <= 1'b0;
            held_cnt <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                ctrl_q   <= ctrl_d;
                held_m   <= d_mul || d_div;
                held_cnt <= d_div ? DIV_CNT : MUL_CNT;
            end
        end
    end

    assign out_valid = (state == ST_VALID);
    assign busy      = (state == ST_WAIT);
    assign RegWrite  = ctrl_q.reg_write;
    assign ALUSrc    = ctrl_q.alu_src;
    assign ALUCtrl   = ctrl_q.alu_ctrl;
    assign IMMSrc    = ctrl_q.imm_src;
    assign MemWrite  = ctrl_q.mem_write;
    assign ResultSrc = ctrl_q.result_src;
    assign branch    = ctrl_q.branch;
    assign MemCtrl   = ctrl_q.mem_ctrl;
    assign jump      = ctrl_q.jump;
    assign JALROn    = ctrl_q.jalr_on;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: u0 without RV32M, u1 with RV32M, both driven by the
// same stimulus and compared each cycle against a transaction-level model.
module tb_decode_stage;

    localparam int MLAT = 2;
    localparam int DLAT = 8;
    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLT = 5'd3, A_SLTU = 5'd4,
                           A_SRA = 5'd7, A_LUI = 5'd10, A_MUL0 = 5'd16;
    localparam logic [19:0] DEF = {1'b0, 1'b1, 5'd0, 3'd0, 1'b0, 2'd0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n, iv, ordy, fl;
    logic [31:0] ins;
    logic        rdy[2], ov[2], bsy[2], ill[2], rw[2], as[2], mw[2], br[2], jp[2], jr[2];
    logic [4:0]  alu[2];
    logic [2:0]  imm[2], mc[2];
    logic [1:0]  rs[2];

    int n_chk = 0;
    int n_err = 0;

    // model state: held flag, remaining hold cycles, latency of held op, controls
    bit          m_vld[2];
    int          m_bl[2];
    int          m_lat[2];
    logic [19:0] m_c[2];

    always #5 clk = ~clk;

    decode_stage #(.EN_MEXT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .instruction(ins), .in_valid(iv), .in_ready(rdy[0]),
        .out_valid(ov[0]), .out_ready(ordy), .flush(fl), .RegWrite(rw[0]), .ALUSrc(as[0]),
        .ALUCtrl(alu[0]), .IMMSrc(imm[0]), .MemWrite(mw[0]), .ResultSrc(rs[0]), .branch(br[0]),
        .MemCtrl(mc[0]), .jump(jp[0]), .JALROn(jr[0]), .illegal(ill[0]), .busy(bsy[0]));

    decode_stage #(.EN_MEXT(1'b1), .MUL_LAT(MLAT), .DIV_LAT(DLAT)) u1 (
        .clk(clk), .rst_n(rst_n), .instruction(ins), .in_valid(iv), .in_ready(rdy[1]),
        .out_valid(ov[1]), .out_ready(ordy), .flush(fl), .RegWrite(rw[1]), .ALUSrc(as[1]),
        .ALUCtrl(alu[1]), .IMMSrc(imm[1]), .MemWrite(mw[1]), .ResultSrc(rs[1]), .branch(br[1]),
        .MemCtrl(mc[1]), .jump(jp[1]), .JALROn(jr[1]), .illegal(ill[1]), .busy(bsy[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] ctrl_of(input int d);
        return {rw[d], as[d], alu[d], imm[d], mw[d], rs[d], br[d], mc[d], jp[d], jr[d], ill[d]};
    endfunction

    // Reference decode, written per mnemonic group from the ISA tables.
    task automatic mdl_dec(input logic [31:0] i, input bit mx, output logic [19:0] c, output int lat);
        logic [4:0] base [8];
        logic [6:0] op, f7;
        logic [2:0] f3, im, m;
        logic [4:0] a;
        logic [1:0] res;
        logic       w, s, mwr, b, j, jl, bad;
        base = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        w = 0; s = 1; a = A_ADD; im = 3'd0; mwr = 0; res = 2'd0; b = 0; m = 3'd2; j = 0; jl = 0;
        bad = 0; lat = 0;
        case (op)
            7'h33: begin
                w = 1; s = 0;
                if (mx && f7 == 7'h01) begin
                    a = A_MUL0 + 5'(f3);
                    lat = (f3 < 4) ? MLAT : DLAT;
                end else if (f7 == 7'h00) a = base[f3];
                else if (f7 == 7'h20 && f3 == 0) a = A_SUB;
                else if (f7 == 7'h20 && f3 == 5) a = A_SRA;
                else bad = 1;
            end
            7'h13: begin
                w = 1; a = base[f3];
                if (f3 == 1 || f3 == 5) begin
                    if (f7 != 7'h00 && f7 != 7'h20) bad = 1;
                    else if (f3 == 5 && f7 == 7'h20) a = A_SRA;
                end
            end
            7'h03: begin
                w = 1; res = 2'd1; m = f3;
                if (f3 == 3 || f3 > 5) bad = 1;
            end
            7'h23: begin
                mwr = 1; im = 3'd1; m = f3;
                if (f3 > 2) bad = 1;
            end
            7'h63: begin
                b = 1; s = 0; im = 3'd2;
                a = (f3 < 2) ? A_SUB : (f3 < 6) ? A_SLT : A_SLTU;
                if (f3 == 2 || f3 == 3) bad = 1;
            end
            7'h6F: begin w = 1; j = 1; im = 3'd4; res = 2'd2; end
            7'h67: begin w = 1; j = 1; jl = 1; res = 2'd2; if (f3 != 0) bad = 1; end
            7'h37: begin w = 1; im = 3'd3; a = A_LUI; end
            7'h17: begin w = 1; im = 3'd3; res = 2'd3; end
            default: bad = 1;
        endcase
        if (bad) begin c = DEF | 20'd1; lat = 0; end
        else c = {w, s, a, im, mwr, res, b, m, j, jl, 1'b0};
    endtask

    // One clock: drive, check at negedge, advance the model, step past posedge.
    task automatic cyc(input logic r, input logic v, input logic [31:0] i, input logic o, input logic f);
        bit e_rdy;
        logic [19:0] c;
        int lat;
        rst_n = r; iv = v; ins = i; ordy = o; fl = f;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e_rdy = r && !f && ((!m_vld[d] && m_bl[d] == 0) || (m_vld[d] && o && m_lat[d] == 0) ||
                                m_bl[d] == 1);
            chk(d ? "u1.in_ready" : "u0.in_ready", 32'(rdy[d]), 32'(e_rdy));
            chk(d ? "u1.out_valid" : "u0.out_valid", 32'(ov[d]), 32'(m_vld[d]));
            chk(d ? "u1.busy" : "u0.busy", 32'(bsy[d]), 32'(m_bl[d] > 0));
            chk(d ? "u1.ctrl" : "u0.ctrl", 32'(ctrl_of(d)), 32'(m_c[d]));
            if (!r) begin
                m_vld[d] = 0; m_bl[d] = 0; m_lat[d] = 0; m_c[d] = DEF;
            end else if (f) begin
                m_vld[d] = 0; m_bl[d] = 0;
            end else begin
                if (m_vld[d] && o) begin
                    m_vld[d] = 0;
                    if (m_lat[d] > 0) m_bl[d] = m_lat[d];
                end else if (m_bl[d] > 0) m_bl[d]--;
                if (v && e_rdy) begin
                    mdl_dec(i, d == 1, c, lat);
                    m_vld[d] = 1; m_c[d] = c; m_lat[d] = lat;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [6:0] ops [9];
        logic [6:0] op, f7;
        int k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        k = $urandom_range(0, 10);
        op = (k < 9) ? ops[k] : 7'($urandom);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 18'($urandom), op};
    endfunction

    initial begin
        logic [19:0] snap;
        int n;
        for (int d = 0; d < 2; d++) begin m_vld[d] = 0; m_bl[d] = 0; m_lat[d] = 0; m_c[d] = DEF; end
        rst_n = 0; iv = 1; ordy = 1; fl = 0; ins = 32'h002081B3;
        repeat (2) @(posedge clk);
        #1;
        // reset: defaults held and in_ready low even with in_valid up
        repeat (3) cyc(0, 1, rnd_ins(), 1, 0);
        cyc(1, 0, 0, 0, 0);

        // add, latency one cycle
        cyc(1, 1, 32'h002081B3, 0, 0);
        chk("add.out_valid", 32'(ov[1]), 1);
        chk("add.RegWrite", 32'(rw[1]), 1);
        chk("add.ALUSrc", 32'(as[1]), 0);
        chk("add.ALUCtrl", 32'(alu[1]), 32'(A_ADD));
        chk("add.illegal", 32'(ill[1]), 0);

        // lw then sw back-to-back
        cyc(1, 1, 32'h0000A183, 1, 0);
        chk("lw.ResultSrc", 32'(rs[1]), 1);
        chk("lw.MemCtrl", 32'(mc[1]), 2);
        cyc(1, 1, 32'h0030A023, 1, 0);
        chk("sw.out_valid", 32'(ov[1]), 1);
        chk("sw.MemWrite", 32'(mw[1]), 1);
        chk("sw.RegWrite", 32'(rw[1]), 0);
        cyc(1, 0, 0, 1, 0);

        // div: ready held low for DIV_LAT-1 cycles after consumption
        cyc(1, 1, 32'h0220C1B3, 0, 0);
        cyc(1, 0, 0, 1, 0);
        chk("div.busy", 32'(bsy[1]), 1);
        n = 0;
        while (!rdy[1] && n < 20) begin
            cyc(1, 0, 0, 0, 0);
            n++;
        end
        chk("div.hold_cycles", 32'(n), 7);
        chk("div.busy_last", 32'(bsy[1]), 1);
        cyc(1, 0, 0, 0, 0);

        // mul without RV32M is illegal and held
        cyc(1, 1, 32'h022081B3, 0, 0);
        chk("mul0.illegal", 32'(ill[0]), 1);
        chk("mul0.RegWrite", 32'(rw[0]), 0);
        chk("mul0.out_valid", 32'(ov[0]), 1);
        cyc(1, 0, 0, 1, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);

        // beq stalled for 5 cycles
        cyc(1, 1, 32'h00208463, 0, 0);
        snap = ctrl_of(1);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, rnd_ins(), 0, 0);
            chk("beq.stable", 32'(ctrl_of(1)), 32'(snap));
            chk("beq.in_ready", 32'(rdy[1]), 0);
        end
        cyc(1, 0, 0, 1, 0);

        // flush aborts WAIT at count 3
        cyc(1, 1, 32'h0220C1B3, 0, 0);
        cyc(1, 0, 0, 1, 0);
        repeat (4) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 32'h002081B3, 0, 1);
        chk("flush.busy", 32'(bsy[1]), 0);
        chk("flush.out_valid", 32'(ov[1]), 0);
        cyc(1, 0, 0, 0, 0);

        // reset pulse mid-VALID
        cyc(1, 1, 32'h0000A183, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst.out_valid", 32'(ov[1]), 0);
        chk("rst.ctrl", 32'(ctrl_of(1)), 32'(DEF));
        cyc(1, 0, 0, 1, 0);

        // random traffic
        for (int k = 0; k < 2000; k++)
            cyc($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, rnd_ins(),
                1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
